rgb_fade_sequencer: RTL and testbench

//  Upstream colour source for the RGB PWM stage. Walks a fixed 8-entry colour table and

---
 rtl/rgb_fade_sequencer_pkg.sv | 17 +
 rtl/rgb_fade_sequencer_prescaler.sv | 17 +
 rtl/rgb_fade_sequencer.sv | 90 +++++++++
 tb/tb_rgb_fade_sequencer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/rgb_fade_sequencer_pkg.sv
// rgb_fade_sequencer_pkg: shared FSM states, colour table and widths for the fade sequencer
package rgb_fade_sequencer_pkg;
  localparam int COLOUR_W = 3;
  localparam int DUTY_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, FADE, HOLD} state_e;
  // One on/off bit per channel as {b,g,r}; a set bit means full scale.
  localparam logic [7:0][2:0] COLOUR_LUT = '{
    7: 3'b000,
    6: 3'b111,
    5: 3'b101,
    4: 3'b100,
    3: 3'b110,
    2: 3'b010,
    1: 3'b011,
    0: 3'b001
  };
endpackage

// File: rtl/rgb_fade_sequencer_prescaler.sv
// rgb_fade_sequencer_prescaler: STEP_DIV-cycle tick generator, cleared while en is low
//   clk, rst (async active-low), en (count enable), tick (one-cycle pulse at STEP_DIV-1)
module rgb_fade_sequencer_prescaler #(
  parameter int STEP_DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(STEP_DIV);
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(STEP_DIV - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (!en || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: walks an 8-colour table, ramping R/G/B duties linearly between colours
//   clk, rst (async active-low), en (run/pause), skip (pulse: next colour now)
//   R_time_out/G_time_out/B_time_out (duties), cur_st (target colour index), fade_busy (in FADE)
module rgb_fade_sequencer
  import rgb_fade_sequencer_pkg::*;
#(
  parameter int STEP_DIV = 1_000_000,
  parameter int HOLD_STEPS = 128,
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                skip,
  output logic [DUTY_W-1:0]   R_time_out,
  output logic [DUTY_W-1:0]   G_time_out,
  output logic [DUTY_W-1:0]   B_time_out,
  output logic [COLOUR_W-1:0] cur_st,
  output logic                fade_busy
);
  localparam int HW = $clog2(HOLD_STEPS + 1);
  state_e state;
  logic tick;
  logic [HW-1:0] hold_cnt;
  logic [2:0] mask;
  logic [2:0] at_tgt;
  logic [2:0][DUTY_W-1:0] duty;
  logic [2:0][DUTY_W-1:0] step;
  rgb_fade_sequencer_prescaler #(.STEP_DIV(STEP_DIV)) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(tick)
  );
  assign mask = COLOUR_LUT[cur_st];
  genvar i;
  for (i = 0; i < 3; i++) begin : g_ch
    logic [DUTY_W-1:0] tgt;
    assign tgt = {DUTY_W{mask[i]}};
    assign at_tgt[i] = duty[i] == tgt;
    // Move one count toward the target; equal means no change, so no overshoot.
    assign step[i] = duty[i] < tgt ? duty[i] + 1'b1 : duty[i] > tgt ? duty[i] - 1'b1 : duty[i];
  end
  assign R_time_out = duty[0];
  assign G_time_out = duty[1];
  assign B_time_out = duty[2];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      duty <= '0;
      cur_st <= '0;
      hold_cnt <= '0;
      fade_busy <= 1'b0;
    end else if (!en) begin
      state <= IDLE;
      fade_busy <= 1'b0;
    end else if (skip && state != IDLE) begin
      // Skip pre-empts any coincident tick: no duty step, no hold count.
      cur_st <= cur_st + 1'b1;
      hold_cnt <= '0;
      state <= FADE;
      fade_busy <= 1'b1;
    end else
      case (state)
        IDLE: begin
          state <= FADE;
          fade_busy <= 1'b1;
        end
        FADE: begin
          if (tick) duty <= step;
          if (&at_tgt) begin
            state <= HOLD;
            hold_cnt <= '0;
            fade_busy <= 1'b0;
          end
        end
        HOLD:
          if (tick) begin
            if (hold_cnt == HW'(HOLD_STEPS - 1)) begin
              cur_st <= cur_st + 1'b1;
              state <= FADE;
              fade_busy <= 1'b1;
            end else hold_cnt <= hold_cnt + 1'b1;
          end
        default: begin
          state <= IDLE;
          fade_busy <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// tb_rgb_fade_sequencer: directed checks of fade, hold, wrap, skip, pause and async reset
module tb_rgb_fade_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic skip = 1'b0;
  logic [7:0] r, g, b;
  logic [2:0] cur_st;
  logic fade_busy;
  int passed = 0;
  int total = 0;
  rgb_fade_sequencer #(.STEP_DIV(4), .HOLD_STEPS(2), .DUTY_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .skip      (skip),
    .R_time_out(r),
    .G_time_out(g),
    .B_time_out(b),
    .cur_st    (cur_st),
    .fade_busy (fade_busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic rgb(input string tag, input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    check({tag, "_r"}, 32'(r), 32'(er));
    check({tag, "_g"}, 32'(g), 32'(eg));
    check({tag, "_b"}, 32'(b), 32'(eb));
  endtask
  initial begin
    step(2);
    rst = 1'b1;
    step(2);
    rgb("rst_state", 8'h00, 8'h00, 8'h00);
    check("rst_cur", 32'(cur_st), 0);
    check("rst_busy", 32'(fade_busy), 0);
    en = 1'b1;
    step(256);
    check("pre_rst_r", 32'(r), 32'h40);
    check("pre_rst_busy", 32'(fade_busy), 1);
    rst = 1'b0;
    #1;
    rgb("async_rst", 8'h00, 8'h00, 8'h00);
    check("async_rst_cur", 32'(cur_st), 0);
    check("async_rst_busy", 32'(fade_busy), 0);
    en = 1'b0;
    step(1);
    rst = 1'b1;
    step(2);
    en = 1'b1;
    step(1);
    check("start_busy", 32'(fade_busy), 1);
    check("start_r", 32'(r), 0);
    step(3);
    check("first_step_r", 32'(r), 1);
    step(4);
    check("second_step_r", 32'(r), 2);
    step(1012);
    rgb("red_reached", 8'hFF, 8'h00, 8'h00);
    check("red_busy", 32'(fade_busy), 1);
    step(1);
    check("hold_busy", 32'(fade_busy), 0);
    step(6);
    check("hold_cur", 32'(cur_st), 0);
    step(1);
    check("adv_cur", 32'(cur_st), 1);
    check("adv_busy", 32'(fade_busy), 1);
    step(4);
    rgb("yellow_start", 8'hFF, 8'h01, 8'h00);
    step(6164);
    check("off_cur", 32'(cur_st), 7);
    rgb("white_reached", 8'hFF, 8'hFF, 8'hFF);
    step(4);
    rgb("off_first", 8'hFE, 8'hFE, 8'hFE);
    step(1016);
    rgb("off_reached", 8'h00, 8'h00, 8'h00);
    step(7);
    check("off_hold_cur", 32'(cur_st), 7);
    step(1);
    check("wrap_cur", 32'(cur_st), 0);
    step(4);
    rgb("wrap_red", 8'h01, 8'h00, 8'h00);
    step(252);
    check("skip_pre_r", 32'(r), 32'h40);
    skip = 1'b1;
    step(1);
    skip = 1'b0;
    check("skip_cur", 32'(cur_st), 1);
    check("skip_r", 32'(r), 32'h40);
    step(3);
    rgb("skip_ramp", 8'h41, 8'h01, 8'h00);
    step(760);
    rgb("skip_r_full", 8'hFF, 8'hBF, 8'h00);
    step(4);
    check("pause_pre_g", 32'(g), 32'hC0);
    en = 1'b0;
    step(1);
    check("pause_busy", 32'(fade_busy), 0);
    step(99);
    rgb("pause_hold", 8'hFF, 8'hC0, 8'h00);
    check("pause_cur", 32'(cur_st), 1);
    en = 1'b1;
    step(3);
    check("resume_busy", 32'(fade_busy), 1);
    check("resume_no_step", 32'(g), 32'hC0);
    step(1);
    check("resume_step", 32'(g), 32'hC1);
    step(3);
    skip = 1'b1;
    step(1);
    skip = 1'b0;
    check("skip_tick_cur", 32'(cur_st), 2);
    rgb("skip_tick", 8'hFF, 8'hC1, 8'h00);
    step(4);
    rgb("green_ramp", 8'hFE, 8'hC2, 8'h00);
    en = 1'b0;
    step(1);
    skip = 1'b1;
    step(1);
    skip = 1'b0;
    step(1);
    check("skip_off_cur", 32'(cur_st), 2);
    en = 1'b1;
    step(1);
    check("skip_off_resume_cur", 32'(cur_st), 2);
    check("skip_off_resume_busy", 32'(fade_busy), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
